// File: rtl/memory_access.sv
// M stage: latches E->M registers, runs the data-bus handshake and holds the pipeline
// via MemBusyM until the access completes; the bus response is forwarded to writeback.
module memory_access #(
  parameter bit STORE_REPLICATE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallM,
  input  logic        FlushM,
  input  logic [31:0] PCE,
  input  logic [31:0] ALUOutE,
  input  logic [31:0] WriteDataE,
  input  logic [4:0]  WriteRegE,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic        SignedE,
  input  logic [2:0]  SizeE,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data,
  output logic        drespM_addr_ok,
  output logic        drespM_data_ok,
  output logic [31:0] drespM_data,
  output logic        MemBusyM,
  output logic [31:0] PCM,
  output logic [31:0] ALUOutM,
  output logic [4:0]  WriteRegM,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic        SignedM,
  output logic [2:0]  SizeM
);

  localparam logic [2:0] MSIZE1 = 3'd0;
  localparam logic [2:0] MSIZE2 = 3'd1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, alu_q, alu_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [4:0]  wreg_q, wreg_d;
  logic        regwrite_q, regwrite_d, memtoreg_q, memtoreg_d;
  logic        memwrite_q, memwrite_d, signed_q, signed_d;
  logic [2:0]  size_q, size_d;
  logic        busy, capture, update;

  // Busy is combinational so the completing cycle itself can advance the pipeline;
  // the register update is gated by it, so flush/stall never abort a live access.
  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    capture    = 1'b0;
    dreq_valid = 1'b0;
    unique case (state_q)
      ADDR: begin
        dreq_valid = 1'b1;
        if (dresp_addr_ok && dresp_data_ok) begin
          state_d = DONE;
          capture = 1'b1;
        end else begin
          busy = 1'b1;
          if (dresp_addr_ok) state_d = DATA;
        end
      end
      DATA: begin
        if (dresp_data_ok) begin
          state_d = DONE;
          capture = 1'b1;
        end else begin
          busy = 1'b1;
        end
      end
      default: ;
    endcase

    update     = !StallM && !busy;
    pc_d       = pc_q;
    alu_d      = alu_q;
    wdata_d    = wdata_q;
    wreg_d     = wreg_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    memwrite_d = memwrite_q;
    signed_d   = signed_q;
    size_d     = size_q;
    if (update) begin
      if (FlushM) begin
        pc_d       = '0;
        alu_d      = '0;
        wdata_d    = '0;
        wreg_d     = '0;
        regwrite_d = 1'b0;
        memtoreg_d = 1'b0;
        memwrite_d = 1'b0;
        signed_d   = 1'b0;
        size_d     = '0;
      end else begin
        pc_d       = PCE;
        alu_d      = ALUOutE;
        wdata_d    = WriteDataE;
        wreg_d     = WriteRegE;
        regwrite_d = RegWriteE;
        memtoreg_d = MemtoRegE;
        memwrite_d = MemWriteE;
        signed_d   = SignedE;
        size_d     = SizeE;
      end
      state_d = (memtoreg_d || memwrite_d) ? ADDR : IDLE;
    end

    rdata_d = capture ? dresp_data : rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      alu_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      wreg_q     <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memwrite_q <= 1'b0;
      signed_q   <= 1'b0;
      size_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      alu_q      <= alu_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      wreg_q     <= wreg_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      memwrite_q <= memwrite_d;
      signed_q   <= signed_d;
      size_q     <= size_d;
    end
  end

  always_comb begin
    dreq_strobe = '0;
    dreq_data   = wdata_q;
    if (size_q == MSIZE1) begin
      if (memwrite_q) dreq_strobe = 4'b0001 << alu_q[1:0];
      if (STORE_REPLICATE) dreq_data = {4{wdata_q[7:0]}};
      else                 dreq_data = {24'b0, wdata_q[7:0]} << {alu_q[1:0], 3'b000};
    end else if (size_q == MSIZE2) begin
      if (memwrite_q) dreq_strobe = alu_q[1] ? 4'b1100 : 4'b0011;
      if (STORE_REPLICATE) dreq_data = {2{wdata_q[15:0]}};
      else                 dreq_data = {16'b0, wdata_q[15:0]} << {alu_q[1:0], 3'b000};
    end else begin
      if (memwrite_q) dreq_strobe = 4'b1111;
    end
  end

  assign dreq_addr      = alu_q;
  assign dreq_size      = size_q;
  assign drespM_addr_ok = capture ? dresp_addr_ok : 1'b0;
  assign drespM_data_ok = capture ? dresp_data_ok : 1'b0;
  assign drespM_data    = capture ? dresp_data : rdata_q;
  assign MemBusyM       = busy;
  assign PCM            = pc_q;
  assign ALUOutM        = alu_q;
  assign WriteRegM      = wreg_q;
  assign RegWriteM      = regwrite_q;
  assign MemtoRegM      = memtoreg_q;
  assign SignedM        = signed_q;
  assign SizeM          = size_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: vector table of single accesses plus hand-written
// multi-cycle handshake, stall, flush and reset sequences; two instances cover both store-data modes.
module tb_memory_access;

  localparam logic [2:0] SZ1 = 3'd0, SZ2 = 3'd1, SZ4 = 3'd2;

  logic        clk = 1'b0, reset, StallM, FlushM;
  logic [31:0] PCE, ALUOutE, WriteDataE;
  logic [4:0]  WriteRegE;
  logic        RegWriteE, MemtoRegE, MemWriteE, SignedE;
  logic [2:0]  SizeE;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [31:0] dresp_data;

  logic        dreq_valid, drespM_addr_ok, drespM_data_ok, MemBusyM;
  logic [31:0] dreq_addr, dreq_data, drespM_data, PCM, ALUOutM;
  logic [2:0]  dreq_size, SizeM;
  logic [3:0]  dreq_strobe;
  logic [4:0]  WriteRegM;
  logic        RegWriteM, MemtoRegM, SignedM;

  logic        s_dreq_valid, s_drespM_addr_ok, s_drespM_data_ok, s_MemBusyM;
  logic [31:0] s_dreq_addr, s_dreq_data, s_drespM_data, s_PCM, s_ALUOutM;
  logic [2:0]  s_dreq_size, s_SizeM;
  logic [3:0]  s_dreq_strobe;
  logic [4:0]  s_WriteRegM;
  logic        s_RegWriteM, s_MemtoRegM, s_SignedM;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  memory_access #(.STORE_REPLICATE(1'b1)) u_rep (
    .clk(clk), .reset(reset), .StallM(StallM), .FlushM(FlushM),
    .PCE(PCE), .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .WriteRegE(WriteRegE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .SignedE(SignedE),
    .SizeE(SizeE),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .drespM_addr_ok(drespM_addr_ok), .drespM_data_ok(drespM_data_ok), .drespM_data(drespM_data),
    .MemBusyM(MemBusyM), .PCM(PCM), .ALUOutM(ALUOutM), .WriteRegM(WriteRegM),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .SignedM(SignedM), .SizeM(SizeM)
  );

  memory_access #(.STORE_REPLICATE(1'b0)) u_sh (
    .clk(clk), .reset(reset), .StallM(StallM), .FlushM(FlushM),
    .PCE(PCE), .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .WriteRegE(WriteRegE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .SignedE(SignedE),
    .SizeE(SizeE),
    .dreq_valid(s_dreq_valid), .dreq_addr(s_dreq_addr), .dreq_size(s_dreq_size),
    .dreq_strobe(s_dreq_strobe), .dreq_data(s_dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .drespM_addr_ok(s_drespM_addr_ok), .drespM_data_ok(s_drespM_data_ok), .drespM_data(s_drespM_data),
    .MemBusyM(s_MemBusyM), .PCM(s_PCM), .ALUOutM(s_ALUOutM), .WriteRegM(s_WriteRegM),
    .RegWriteM(s_RegWriteM), .MemtoRegM(s_MemtoRegM), .SignedM(s_SignedM), .SizeM(s_SizeM)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  strb;
    logic [31:0] drep;
    logic [31:0] dsh;
    logic        chkd;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    PCE = '0; ALUOutE = '0; WriteDataE = '0; WriteRegE = '0;
    RegWriteE = 1'b0; MemtoRegE = 1'b0; MemWriteE = 1'b0; SignedE = 1'b0; SizeE = SZ4;
  endtask

  task automatic set_op(input logic rw, input logic rd, input logic wr, input logic sg,
                        input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] wd);
    PCE = 32'hBFC0_0100; ALUOutE = addr; WriteDataE = wd; WriteRegE = 5'd9;
    RegWriteE = rw; MemtoRegE = rd; MemWriteE = wr; SignedE = sg; SizeE = sz;
  endtask

  task automatic set_resp(input logic aok, input logic dok, input logic [31:0] d);
    dresp_addr_ok = aok; dresp_data_ok = dok; dresp_data = d;
  endtask

  initial begin
    int unsigned vcnt, bcnt;
    //        wr    size addr           wd             strb     rep            shifted        chkd
    vt[0] = '{1'b1, SZ1, 32'h0000_0010, 32'h1234_5678, 4'b0001, 32'h7878_7878, 32'h0000_0078, 1'b1};
    vt[1] = '{1'b1, SZ1, 32'h0000_0011, 32'hCAFE_00C3, 4'b0010, 32'hC3C3_C3C3, 32'h0000_C300, 1'b1};
    vt[2] = '{1'b1, SZ1, 32'h0000_0012, 32'h0000_005A, 4'b0100, 32'h5A5A_5A5A, 32'h005A_0000, 1'b1};
    vt[3] = '{1'b1, SZ2, 32'h8000_0002, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF, 32'hBEEF_0000, 1'b1};
    vt[4] = '{1'b1, SZ2, 32'h0000_0020, 32'hAAAA_7788, 4'b0011, 32'h7788_7788, 32'h0000_7788, 1'b1};
    vt[5] = '{1'b1, SZ4, 32'h0000_0024, 32'h0102_0304, 4'b1111, 32'h0102_0304, 32'h0102_0304, 1'b1};
    vt[6] = '{1'b0, SZ4, 32'h0000_0028, 32'hFFFF_FFFF, 4'b0000, 32'h0,         32'h0,         1'b0};
    vt[7] = '{1'b0, SZ1, 32'h0000_002B, 32'h0000_00FF, 4'b0000, 32'h0,         32'h0,         1'b0};
    vt[8] = '{1'b1, SZ2, 32'h0000_0031, 32'h0000_ABCD, 4'b0011, 32'hABCD_ABCD, 32'h00AB_CD00, 1'b1};
    vt[9] = '{1'b1, SZ4, 32'h0000_0036, 32'h9876_5432, 4'b1111, 32'h9876_5432, 32'h9876_5432, 1'b1};

    reset = 1'b1; StallM = 1'b0; FlushM = 1'b0;
    set_nop();
    set_resp(1'b0, 1'b0, '0);
    #2;
    chk("rst_valid", {31'b0, dreq_valid}, 32'd0);
    chk("rst_busy", {31'b0, MemBusyM}, 32'd0);
    chk("rst_alu", ALUOutM, 32'd0);
    chk("rst_drespM", drespM_data, 32'd0);
    chk("rst_regwrite", {31'b0, RegWriteM}, 32'd0);
    tick();
    reset = 1'b0;

    // ALU-only op passes through without a bus request
    set_op(1'b1, 1'b0, 1'b0, 1'b0, SZ4, 32'h0000_1234, 32'h0);
    tick();
    chk("alu_out", ALUOutM, 32'h0000_1234);
    chk("alu_pc", PCM, 32'hBFC0_0100);
    chk("alu_regwrite", {31'b0, RegWriteM}, 32'd1);
    chk("alu_valid", {31'b0, dreq_valid}, 32'd0);
    chk("alu_busy", {31'b0, MemBusyM}, 32'd0);
    set_nop();
    tick();

    // Table of single accesses, each completed with addr_ok+data_ok in the first cycle
    for (int i = 0; i < 10; i++) begin
      set_op(!vt[i].wr, !vt[i].wr, vt[i].wr, 1'b0, vt[i].size, vt[i].addr, vt[i].wd);
      tick();
      chk($sformatf("v%0d_valid", i), {31'b0, dreq_valid}, 32'd1);
      chk($sformatf("v%0d_addr", i), dreq_addr, vt[i].addr);
      chk($sformatf("v%0d_size", i), {29'b0, dreq_size}, {29'b0, vt[i].size});
      chk($sformatf("v%0d_strobe", i), {28'b0, dreq_strobe}, {28'b0, vt[i].strb});
      if (vt[i].chkd) begin
        chk($sformatf("v%0d_data_rep", i), dreq_data, vt[i].drep);
        chk($sformatf("v%0d_data_sh", i), s_dreq_data, vt[i].dsh);
      end
      set_nop();
      set_resp(1'b1, 1'b1, 32'h1000_0000 + i);
      #1;
      chk($sformatf("v%0d_busy", i), {31'b0, MemBusyM}, 32'd0);
      chk($sformatf("v%0d_resp", i), drespM_data, 32'h1000_0000 + i);
      tick();
      set_resp(1'b0, 1'b0, '0);
      #1;
      chk($sformatf("v%0d_idle_valid", i), {31'b0, dreq_valid}, 32'd0);
    end

    // LW completing under stall, then held in DONE while dresp changes
    set_op(1'b1, 1'b1, 1'b0, 1'b0, SZ4, 32'h8000_0010, 32'h0);
    tick();
    chk("lw_valid", {31'b0, dreq_valid}, 32'd1);
    set_nop();
    StallM = 1'b1;
    set_resp(1'b1, 1'b1, 32'hDEAD_BEEF);
    #1;
    chk("lw_busy", {31'b0, MemBusyM}, 32'd0);
    chk("lw_drespM", drespM_data, 32'hDEAD_BEEF);
    chk("lw_drespM_ok", {31'b0, drespM_data_ok}, 32'd1);
    tick();
    set_resp(1'b0, 1'b0, 32'h0);
    #1;
    chk("done_valid", {31'b0, dreq_valid}, 32'd0);
    chk("done_busy", {31'b0, MemBusyM}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      set_resp(1'b0, (c == 2), (c == 2) ? 32'h1111_1111 : 32'h0);
      #1;
      chk($sformatf("done%0d_data", c), drespM_data, 32'hDEAD_BEEF);
      chk($sformatf("done%0d_ok", c), {31'b0, drespM_data_ok}, 32'd0);
      chk($sformatf("done%0d_alu", c), ALUOutM, 32'h8000_0010);
      tick();
    end
    StallM = 1'b0;
    set_resp(1'b0, 1'b0, '0);
    tick();
    chk("done_release_alu", ALUOutM, 32'd0);

    // SB with addr_ok on cycle 3 and data_ok on cycle 6
    set_op(1'b0, 1'b0, 1'b1, 1'b0, SZ1, 32'h8000_0013, 32'h0000_00A5);
    tick();
    set_nop();
    chk("sb_strobe", {28'b0, dreq_strobe}, 32'h8);
    chk("sb_data_rep", dreq_data, 32'hA5A5_A5A5);
    chk("sb_data_sh", s_dreq_data, 32'hA500_0000);
    vcnt = 0; bcnt = 0;
    for (int c = 1; c <= 6; c++) begin
      set_resp((c == 3), (c == 6), 32'h0);
      #1;
      if (dreq_valid) vcnt++;
      if (MemBusyM) bcnt++;
      chk($sformatf("sb_c%0d_alu", c), ALUOutM, 32'h8000_0013);
      if (c == 6) chk("sb_c6_busy", {31'b0, MemBusyM}, 32'd0);
      tick();
    end
    set_resp(1'b0, 1'b0, '0);
    chk("sb_valid_cycles", vcnt, 32'd3);
    chk("sb_busy_cycles", bcnt, 32'd5);
    chk("sb_after_valid", {31'b0, dreq_valid}, 32'd0);

    // LH with FlushM asserted in DATA: register held until data_ok, then bubble
    set_op(1'b1, 1'b1, 1'b0, 1'b1, SZ2, 32'h8000_0006, 32'h0);
    tick();
    set_op(1'b1, 1'b0, 1'b0, 1'b0, SZ4, 32'h0000_5555, 32'h0);
    FlushM = 1'b1;
    set_resp(1'b1, 1'b0, '0);
    tick();
    set_resp(1'b0, 1'b0, '0);
    #1;
    chk("lh_data_busy", {31'b0, MemBusyM}, 32'd1);
    chk("lh_data_alu", ALUOutM, 32'h8000_0006);
    chk("lh_data_signed", {31'b0, SignedM}, 32'd1);
    tick();
    chk("lh_hold_memtoreg", {31'b0, MemtoRegM}, 32'd1);
    set_resp(1'b0, 1'b1, 32'h0000_F00D);
    #1;
    chk("lh_done_busy", {31'b0, MemBusyM}, 32'd0);
    chk("lh_drespM", drespM_data, 32'h0000_F00D);
    tick();
    set_resp(1'b0, 1'b0, '0);
    FlushM = 1'b0;
    set_nop();
    chk("lh_bubble_alu", ALUOutM, 32'd0);
    chk("lh_bubble_regwrite", {31'b0, RegWriteM}, 32'd0);
    chk("lh_bubble_memtoreg", {31'b0, MemtoRegM}, 32'd0);
    chk("lh_bubble_valid", {31'b0, dreq_valid}, 32'd0);
    chk("lh_keep_resp", drespM_data, 32'h0000_F00D);

    // Reset while in ADDR
    set_op(1'b1, 1'b1, 1'b0, 1'b0, SZ4, 32'h8000_0040, 32'h0);
    tick();
    chk("ra_valid", {31'b0, dreq_valid}, 32'd1);
    set_nop();
    reset = 1'b1;
    #1;
    chk("ra_valid_rst", {31'b0, dreq_valid}, 32'd0);
    chk("ra_busy_rst", {31'b0, MemBusyM}, 32'd0);
    chk("ra_alu_rst", ALUOutM, 32'd0);
    chk("ra_pc_rst", PCM, 32'd0);
    chk("ra_memtoreg_rst", {31'b0, MemtoRegM}, 32'd0);
    chk("ra_drespM_rst", drespM_data, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("ra_idle_valid", {31'b0, dreq_valid}, 32'd0);
    chk("ra_idle_busy", {31'b0, MemBusyM}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
